// File: rtl/uart_rx.sv
// 8N1 UART receiver oversampled by a 16x sample strobe (sysclk_sam used as data).
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       sysclk_sam,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t             state, state_nx;
  logic               rx_meta, rx_s;
  logic               sam_meta, sam_s, sam_d;
  logic               tick;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [IDX_W-1:0]   bidx, bidx_nx;
  logic [DATA_W-1:0]  shift_reg, shift_reg_nx;
  logic [DATA_W-1:0]  data_nx;
  logic               valid_nx, ferr_nx, busy_nx;
`ifdef UART_RX_PARITY_EN
  logic               par_bad, par_bad_nx;
  logic               perr_nx;
`endif

  // Two-flop synchronizers; rx idles high, the sample strobe idles low.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      sam_meta <= 1'b0;
      sam_s    <= 1'b0;
      sam_d    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      sam_meta <= sysclk_sam;
      sam_s    <= sam_meta;
      sam_d    <= sam_s;
    end
  end

  assign tick = sam_s & ~sam_d;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and datapath updates; nothing moves except on a tick.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bidx_nx      = bidx;
    shift_reg_nx = shift_reg;
    data_nx      = rx_data;
    valid_nx     = 1'b0;
    ferr_nx      = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nx      = 1'b0;
    par_bad_nx   = par_bad;
`endif
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nx = START;
            cnt_nx   = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_nx = 1'b0;
`endif
          end
        end
        START: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_W'(7)) begin
            if (!rx_s) begin
              state_nx = DATA;
              cnt_nx   = '0;
              bidx_nx  = '0;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        DATA: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_W'(15)) begin
            shift_reg_nx = {rx_s, shift_reg[DATA_W-1:1]};
            bidx_nx      = bidx + IDX_W'(1);
            if (bidx == IDX_W'(7)) begin
`ifdef UART_RX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_W'(15)) begin
            if (rx_s != ^shift_reg) begin
              perr_nx    = 1'b1;
              par_bad_nx = 1'b1;
            end
            state_nx = STOP;
          end
        end
`endif
        STOP: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_W'(15)) begin
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (!par_bad) begin
                data_nx  = shift_reg;
                valid_nx = 1'b1;
              end
`else
              data_nx  = shift_reg;
              valid_nx = 1'b1;
`endif
              state_nx = IDLE;
            end else begin
              ferr_nx  = 1'b1;
              state_nx = BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      bidx      <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      bidx      <= bidx_nx;
      shift_reg <= shift_reg_nx;
      rx_data   <= data_nx;
      rx_valid  <= valid_nx;
      rx_busy   <= busy_nx;
      frame_err <= ferr_nx;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nx;
      parity_err <= perr_nx;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
